// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard unit: select encodings,
// register address width and the stall FSM state encoding.
package fwd_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } fwd_state_e;

endpackage

// File: rtl/fwd_match.sv
// Per-source comparator: detects producers in ID/EX and EX/MEM that write
// this source register and picks the forward select it will need in EX.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic              use_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_regwrite_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_regwrite_i,
    output logic              match_ex_o,
    output logic              match_mem_o,
    output logic [1:0]        next_sel_o
);

    // x0 is hard-wired to zero, so a producer targeting it never matches.
    assign match_ex_o  = use_i & ex_regwrite_i  & (ex_rd_i  != '0) & (ex_rd_i  == rs_i);
    assign match_mem_o = use_i & mem_regwrite_i & (mem_rd_i != '0) & (mem_rd_i == rs_i);

    // The younger producer (ID/EX now, EX/MEM when we reach EX) wins.
    always_comb begin
        next_sel_o = FWD_NONE;
        if (FWD_EN != 0) begin
            if (match_ex_o) begin
                next_sel_o = FWD_EXMEM;
            end else if (match_mem_o) begin
                next_sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select generation and load-use / interlock stall control with
// stall-cycle and stall-event performance counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      hold_i,
    input  logic [REG_AW*NUM_SRC-1:0] id_rs_i,
    input  logic [NUM_SRC-1:0]        id_rs_use_i,
    input  logic [REG_AW-1:0]         ex_rd_i,
    input  logic                      ex_regwrite_i,
    input  logic                      ex_memread_i,
    input  logic [REG_AW-1:0]         mem_rd_i,
    input  logic                      mem_regwrite_i,
    output logic [2*NUM_SRC-1:0]      ex_fwd_o,
    output logic                      stall_o,
    output logic                      bubble_o,
    output logic [CNT_W-1:0]          stall_cyc_o,
    output logic [CNT_W-1:0]          stall_evt_o
);

    logic [NUM_SRC-1:0]   match_ex;
    logic [NUM_SRC-1:0]   match_mem;
    logic [2*NUM_SRC-1:0] next_sel;
    logic                 hazard;

    fwd_state_e           state_q, state_d;
    logic [2*NUM_SRC-1:0] fwd_q, fwd_d;
    logic [CNT_W-1:0]     stall_cyc_q, stall_cyc_d;
    logic [CNT_W-1:0]     stall_evt_q, stall_evt_d;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_match #(
            .FWD_EN (FWD_EN)
        ) u_match (
            .rs_i           (id_rs_i[REG_AW*k +: REG_AW]),
            .use_i          (id_rs_use_i[k]),
            .ex_rd_i        (ex_rd_i),
            .ex_regwrite_i  (ex_regwrite_i),
            .mem_rd_i       (mem_rd_i),
            .mem_regwrite_i (mem_regwrite_i),
            .match_ex_o     (match_ex[k]),
            .match_mem_o    (match_mem[k]),
            .next_sel_o     (next_sel[2*k +: 2])
        );
    end

    // Without forwarding every in-flight producer must drain before ID proceeds.
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            hazard = (|match_ex) & ex_memread_i;
        end else begin
            hazard = |(match_ex | match_mem);
        end
    end

    assign stall_o  = hazard & ~rst_i;
    assign bubble_o = hazard & ~hold_i & ~rst_i;

    always_comb begin
        state_d     = state_q;
        fwd_d       = fwd_q;
        stall_cyc_d = stall_cyc_q;
        stall_evt_d = stall_evt_q;
        if (!hold_i) begin
            state_d = hazard ? ST_STALL : ST_RUN;
            fwd_d   = hazard ? '0 : next_sel;
            if (hazard && (stall_cyc_q != '1)) begin
                stall_cyc_d = stall_cyc_q + CNT_W'(1);
            end
            // Only the entry into a stall counts as an event.
            if (hazard && (state_q == ST_RUN) && (stall_evt_q != '1)) begin
                stall_evt_d = stall_evt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            fwd_q       <= '0;
            stall_cyc_q <= '0;
            stall_evt_q <= '0;
        end else begin
            state_q     <= state_d;
            fwd_q       <= fwd_d;
            stall_cyc_q <= stall_cyc_d;
            stall_evt_q <= stall_evt_d;
        end
    end

    assign ex_fwd_o    = fwd_q;
    assign stall_cyc_o = stall_cyc_q;
    assign stall_evt_o = stall_evt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: a forwarding instance (32-bit counters) and an interlock-only
// instance (2-bit counters, to reach saturation) driven by the same inputs.
module tb_fwd_hazard_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        hold_i;
    logic [9:0]  id_rs;
    logic [1:0]  id_use;
    logic [4:0]  ex_rd;
    logic        ex_rw;
    logic        ex_mr;
    logic [4:0]  mem_rd;
    logic        mem_rw;

    logic [3:0]  fwd1;
    logic        stall1;
    logic        bubble1;
    logic [31:0] cyc1;
    logic [31:0] evt1;

    logic [3:0]  fwd0;
    logic        stall0;
    logic        bubble0;
    logic [1:0]  cyc0;
    logic [1:0]  evt0;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    fwd_hazard_unit #(
        .NUM_SRC (2),
        .FWD_EN  (1),
        .CNT_W   (32)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .hold_i         (hold_i),
        .id_rs_i        (id_rs),
        .id_rs_use_i    (id_use),
        .ex_rd_i        (ex_rd),
        .ex_regwrite_i  (ex_rw),
        .ex_memread_i   (ex_mr),
        .mem_rd_i       (mem_rd),
        .mem_regwrite_i (mem_rw),
        .ex_fwd_o       (fwd1),
        .stall_o        (stall1),
        .bubble_o       (bubble1),
        .stall_cyc_o    (cyc1),
        .stall_evt_o    (evt1)
    );

    fwd_hazard_unit #(
        .NUM_SRC (2),
        .FWD_EN  (0),
        .CNT_W   (2)
    ) dut_il (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .hold_i         (hold_i),
        .id_rs_i        (id_rs),
        .id_rs_use_i    (id_use),
        .ex_rd_i        (ex_rd),
        .ex_regwrite_i  (ex_rw),
        .ex_memread_i   (ex_mr),
        .mem_rd_i       (mem_rd),
        .mem_regwrite_i (mem_rw),
        .ex_fwd_o       (fwd0),
        .stall_o        (stall0),
        .bubble_o       (bubble0),
        .stall_cyc_o    (cyc0),
        .stall_evt_o    (evt0)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] use_bits,
                                 input logic [4:0] erd, input logic erw, input logic emr,
                                 input logic [4:0] mrd, input logic mrw, input logic hold);
        id_rs  = {rs2, rs1};
        id_use = use_bits;
        ex_rd  = erd;
        ex_rw  = erw;
        ex_mr  = emr;
        mem_rd = mrd;
        mem_rw = mrw;
        hold_i = hold;
    endtask

    task automatic nextCycle;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        // Reset with a load-use hazard present: outputs must stay quiet.
        applyStimulus(5'd5, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        #1 rst_i = 1'b1;
        #2;
        checkOutput("rst_fwd", fwd1, 4'b0000);
        checkOutput("rst_stall", stall1, 1'b0);
        checkOutput("rst_bubble", bubble1, 1'b0);
        checkOutput("rst_cyc", cyc1, 32'd0);
        checkOutput("rst_evt", evt1, 32'd0);
        checkOutput("rst_stall_il", stall0, 1'b0);

        // add x5 in EX, sub x6,x5,x7 in ID: forward from EX/MEM, no stall.
        @(negedge clk_i);
        applyStimulus(5'd5, 5'd7, 2'b11, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        rst_i = 1'b0;
        #1;
        checkOutput("alu_stall", stall1, 1'b0);
        nextCycle();
        checkOutput("alu_fwd", fwd1, 4'b0010);
        checkOutput("alu_cyc", cyc1, 32'd0);

        // lw x5 in ID/EX with ID reading x5: one stall cycle then MEM/WB forward.
        applyStimulus(5'd5, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        checkOutput("lu_stall", stall1, 1'b1);
        checkOutput("lu_bubble", bubble1, 1'b1);
        nextCycle();
        checkOutput("lu_fwd", fwd1, 4'b0000);
        checkOutput("lu_cyc", cyc1, 32'd1);
        checkOutput("lu_evt", evt1, 32'd1);
        applyStimulus(5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        #1;
        checkOutput("lu2_stall", stall1, 1'b0);
        nextCycle();
        checkOutput("lu2_fwd", fwd1, 4'b0001);
        checkOutput("lu2_cyc", cyc1, 32'd1);
        checkOutput("lu2_evt", evt1, 32'd1);

        // Both stages write x3: EX/MEM has priority.
        applyStimulus(5'd3, 5'd3, 2'b11, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        #1;
        checkOutput("prio_stall", stall1, 1'b0);
        nextCycle();
        checkOutput("prio_fwd", fwd1, 4'b1010);

        // x0 never matches, even as a load destination.
        applyStimulus(5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        #1;
        checkOutput("x0_stall", stall1, 1'b0);
        nextCycle();
        checkOutput("x0_fwd", fwd1, 4'b0000);

        // Second source forwarded from MEM/WB.
        applyStimulus(5'd1, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
        nextCycle();
        checkOutput("rs2_fwd", fwd1, 4'b0100);

        // Unused sources never match.
        applyStimulus(5'd9, 5'd9, 2'b00, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        #1;
        checkOutput("nouse_stall", stall1, 1'b0);
        nextCycle();
        checkOutput("nouse_fwd", fwd1, 4'b0000);

        // Establish a non-zero select, then freeze with a load-use hazard pending.
        applyStimulus(5'd8, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("pre_hold_fwd", fwd1, 4'b0010);
        applyStimulus(5'd0, 5'd8, 2'b10, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("hold_stall", stall1, 1'b1);
            checkOutput("hold_bubble", bubble1, 1'b0);
            nextCycle();
            checkOutput("hold_fwd", fwd1, 4'b0010);
            checkOutput("hold_cyc", cyc1, 32'd1);
            checkOutput("hold_evt", evt1, 32'd1);
        end

        // Release the hold: the stall proceeds from RUN and counts as a new event.
        hold_i = 1'b0;
        #1;
        checkOutput("rel_bubble", bubble1, 1'b1);
        nextCycle();
        checkOutput("rel_fwd", fwd1, 4'b0000);
        checkOutput("rel_cyc", cyc1, 32'd2);
        checkOutput("rel_evt", evt1, 32'd2);
        nextCycle();
        checkOutput("b2b_cyc", cyc1, 32'd3);
        checkOutput("b2b_evt", evt1, 32'd2);

        // Asynchronous reset in the middle of a stall.
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("arst_fwd", fwd1, 4'b0000);
        checkOutput("arst_cyc", cyc1, 32'd0);
        checkOutput("arst_evt", evt1, 32'd0);
        checkOutput("arst_stall", stall1, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checkOutput("post_rst_stall", stall1, 1'b1);
        nextCycle();
        checkOutput("post_rst_evt", evt1, 32'd1);
        checkOutput("post_rst_cyc", cyc1, 32'd1);

        // Interlock-only instance: MEM-stage producer of rs2 held for 2 cycles.
        rst_i = 1'b1;
        applyStimulus(5'd1, 5'd4, 2'b11, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
        #1;
        checkOutput("il_rst_cyc", cyc0, 2'd0);
        checkOutput("il_rst_evt", evt0, 2'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checkOutput("il_stall", stall0, 1'b1);
        checkOutput("il_bubble", bubble0, 1'b1);
        checkOutput("fw_no_stall", stall1, 1'b0);
        nextCycle();
        checkOutput("il_fwd1", fwd0, 4'b0000);
        checkOutput("il_cyc1", cyc0, 2'd1);
        checkOutput("il_evt1", evt0, 2'd1);
        checkOutput("fw_mem_fwd", fwd1, 4'b0100);
        nextCycle();
        checkOutput("il_fwd2", fwd0, 4'b0000);
        checkOutput("il_cyc2", cyc0, 2'd2);
        checkOutput("il_evt2", evt0, 2'd1);
        mem_rw = 1'b0;
        #1;
        checkOutput("il_clear_stall", stall0, 1'b0);
        nextCycle();
        checkOutput("il_clear_cyc", cyc0, 2'd2);
        checkOutput("il_clear_evt", evt0, 2'd1);

        // Drive both 2-bit counters into saturation.
        mem_rw = 1'b1;
        nextCycle();
        checkOutput("sat_cyc3", cyc0, 2'd3);
        checkOutput("sat_evt2", evt0, 2'd2);
        nextCycle();
        checkOutput("sat_cyc_hold", cyc0, 2'd3);
        checkOutput("sat_evt_b2b", evt0, 2'd2);
        mem_rw = 1'b0;
        nextCycle();
        mem_rw = 1'b1;
        nextCycle();
        checkOutput("sat_evt3", evt0, 2'd3);
        mem_rw = 1'b0;
        nextCycle();
        mem_rw = 1'b1;
        nextCycle();
        checkOutput("sat_evt_hold", evt0, 2'd3);
        checkOutput("sat_cyc_final", cyc0, 2'd3);
        checkOutput("il_fwd_final", fwd0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NUM_SRC, default 2: number of source-register read ports checked per instruction, range 1..4.
REQ-002 Parameter FWD_EN, default 1: 1 = full forwarding plus load-use stall; 0 = interlock-only, with no forwarding and a stall on any in-flight match.
REQ-003 Parameter CNT_W, default 32: width of the performance counters.
REQ-004 clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous and active-high.
REQ-006 hold_i  in  1  external pipeline freeze (memory wait); all state is frozen while it is high.
REQ-007 id_rs_i  in  5*NUM_SRC  ID-stage source register addresses; source k occupies bits [5k+4:5k].
REQ-008 id_rs_use_i  in  NUM_SRC  bit k high means source k is actually read by the ID instruction.
REQ-009 ex_rd_i, ex_regwrite_i, ex_memread_i  in  5/1/1  ID/EX-register producer: destination, writes-register, is-load.
REQ-010 mem_rd_i, mem_regwrite_i  in  5/1  EX/MEM-register producer: destination, writes-register.
REQ-011 ex_fwd_o  out  2*NUM_SRC  registered forward select for the instruction entering EX; 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
REQ-012 stall_o  out  1  combinational; holds PC and IF/ID.
REQ-013 bubble_o  out  1  combinational; zeroes the ID/EX control bits.
REQ-014 stall_cyc_o, stall_evt_o  out  CNT_W each  stalled-cycle count and stall-event count.

Function
REQ-015 match_ex[k] SHALL be: use[k] & ex_regwrite_i & ex_rd_i!=0 & ex_rd_i==rs[k]. match_mem[k] SHALL be the same using the mem_ signals.
REQ-016 With FWD_EN=1, hazard SHALL be: OR over k of (match_ex[k] & ex_memread_i).
REQ-017 With FWD_EN=0, hazard SHALL be: OR over k of (match_ex[k] | match_mem[k]).
REQ-018 Next select for source k SHALL be:
- 10 if match_ex[k];
- else 01 if match_mem[k];
- else 00.
This is because the ID/EX producer sits in EX/MEM and the EX/MEM producer sits in MEM/WB when the consumer reaches EX. With FWD_EN=0 the next select SHALL always be 00.
REQ-019 A producer currently in MEM/WB SHALL NOT be checked; the register file's write-first read covers it.
REQ-020 stall_o SHALL equal hazard, and bubble_o SHALL equal hazard & !hold_i. Both SHALL be 0 while rst_i is high.
REQ-021 On each edge with hold_i=0, ex_fwd_o SHALL load 00 for all sources if hazard is set, otherwise the next selects. With hold_i=1 it SHALL retain its value.
REQ-022 Latency: a select computed in cycle n SHALL appear on ex_fwd_o in cycle n+1, aligned with the ID/EX register.
REQ-023 The FSM SHALL have states RUN and STALL; hold_i=1 keeps the current state.
- RUN -> STALL on hazard & !hold_i.
- STALL -> RUN on !hazard & !hold_i.
- STALL -> STALL on hazard & !hold_i.
REQ-024 stall_evt_o SHALL increment on each RUN -> STALL transition only, so back-to-back stall cycles count as one event.
REQ-025 stall_cyc_o SHALL increment on each edge where hazard & !hold_i.
REQ-026 Both counters SHALL saturate at all-ones and never wrap.
REQ-027 Simultaneous hazard and hold_i: stall_o=1, bubble_o=0, and no state, select or counter change.
REQ-028 Source register x0, or use[k]=0, SHALL never match, forward or stall.

Reset
REQ-029 Asserting rst_i SHALL immediately set ex_fwd_o=0, state=RUN, stall_cyc_o=0 and stall_evt_o=0, independent of clk_i.
REQ-030 Reset asserted mid-stall SHALL abandon the stall. The first edge after release SHALL evaluate hazard afresh from RUN.

Structure
REQ-031 Shared package fwd_pkg SHALL hold:
- FWD_NONE=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01;
- REG_AW=5;
- the RUN/STALL state encoding.
REQ-032 A sub-module fwd_match SHALL implement one source's match_ex/match_mem and next-select logic, instantiated NUM_SRC times.

Verification
REQ-033 Sequence add x5 in EX stage, then sub x6,x5,x7 in ID with use=11 -> next cycle ex_fwd_o[1:0]=10, stall_o never asserted.
REQ-034 lw x5 in ID/EX (memread=1) with ID reading x5 -> stall_o=1 for 1 cycle, ex_fwd_o=0, stall_evt_o=1, stall_cyc_o=1. The next cycle gives select 01.
REQ-035 ex_rd=mem_rd=x3, both regwrite, rs1=x3 -> select 10 (EX/MEM priority). ex_rd=x0 with rs1=x0 -> select 00.
REQ-036 FWD_EN=0, mem_rd=x4 matches rs2 for 2 cycles -> stall_o high for 2 cycles, stall_cyc_o=2, stall_evt_o=1, ex_fwd_o always 0.
REQ-037 Load-use hazard with hold_i=1 for 3 cycles -> bubble_o=0, counters and ex_fwd_o unchanged. rst_i pulsed during STALL -> outputs 0 asynchronously.
